// File: rtl/pac_rx_deframer.sv
// pac_rx_deframer: splits the 125 MHz byte stream into packets on each
// pac_stp pulse, validates the 4-byte header, streams the payload with
// sop/eop markers and checks the trailing big-endian 16-bit sum.
module pac_rx_deframer #(
  parameter logic [7:0] SYNC0     = 8'hA5,
  parameter logic [7:0] SYNC1     = 8'h5A,
  parameter int         VID_FIRST = 16,
  parameter int         LEN_VID   = 1943,
  parameter int         LEN_OTH   = 2071
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pac_stp,
  input  logic [7:0]  rx_data,
  output logic [7:0]  pay_data,
  output logic        pay_vld,
  output logic        pay_sop,
  output logic        pay_eop,
  output logic [10:0] pkt_num,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic [15:0] err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] CHK  = 2'd3;

  localparam logic [11:0] VID_W = 12'(VID_FIRST);
  localparam logic [11:0] LV_W  = 12'(LEN_VID);
  localparam logic [11:0] LO_W  = 12'(LEN_OTH);

  logic [1:0]  state, state_nxt;
  logic [11:0] idx, idx_nxt;
  logic [15:0] sum, sum_nxt;
  logic [7:0]  chk_hi, chk_hi_nxt;
  logic [2:0]  num_hi, num_hi_nxt;
  logic [11:0] pkt_len, pkt_len_nxt;

  logic [7:0]  pay_data_nxt;
  logic        pay_vld_nxt, pay_sop_nxt, pay_eop_nxt;
  logic [10:0] pkt_num_nxt;
  logic        pkt_ok_nxt, pkt_err_nxt;
  logic [2:0]  err_code_nxt;

  logic        active, hdr_bad;
  logic [1:0]  cur_st;
  logic [11:0] cur_idx;

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-byte decode: a pac_stp always makes the current byte i0 of a fresh
  // header, aborting whatever packet was still in progress.
  always_comb begin
    active       = pac_stp || (state != IDLE);
    cur_st       = pac_stp ? HDR : state;
    cur_idx      = pac_stp ? 12'd0 : idx;
    hdr_bad      = 1'b0;
    state_nxt    = state;
    idx_nxt      = active ? cur_idx + 12'd1 : idx;
    sum_nxt      = sum;
    chk_hi_nxt   = chk_hi;
    num_hi_nxt   = num_hi;
    pkt_len_nxt  = pkt_len;
    pay_data_nxt = 8'd0;
    pay_vld_nxt  = 1'b0;
    pay_sop_nxt  = 1'b0;
    pay_eop_nxt  = 1'b0;
    pkt_num_nxt  = pkt_num;
    pkt_ok_nxt   = 1'b0;
    pkt_err_nxt  = 1'b0;
    err_code_nxt = 3'b000;

    // Truncated packet. The eop closing a cut payload is a bare marker
    // (pay_vld low) so the new packet's sync byte never leaks into it.
    if (pac_stp && (state != IDLE)) begin
      pkt_err_nxt     = 1'b1;
      err_code_nxt[2] = 1'b1;
      pay_eop_nxt     = (state == PAY);
    end

    if (active) begin
      case (cur_st)
        HDR: begin
          sum_nxt = ((cur_idx == 12'd0) ? 16'd0 : sum) + {8'd0, rx_data};
          if (cur_idx == 12'd0)      hdr_bad = (rx_data != SYNC0);
          else if (cur_idx == 12'd1) hdr_bad = (rx_data != SYNC1);
          else if (cur_idx == 12'd2) hdr_bad = |rx_data[7:3];
          state_nxt = HDR;
          if (hdr_bad) begin
            pkt_err_nxt     = 1'b1;
            err_code_nxt[1] = 1'b1;
            state_nxt       = IDLE;
          end else if (cur_idx == 12'd2) begin
            num_hi_nxt = rx_data[2:0];
          end else if (cur_idx == 12'd3) begin
            pkt_num_nxt = {num_hi, rx_data};
            pkt_len_nxt = ({1'b0, num_hi, rx_data} >= VID_W) ? LV_W : LO_W;
            state_nxt   = PAY;
          end
        end
        PAY: begin
          sum_nxt      = sum + {8'd0, rx_data};
          pay_data_nxt = rx_data;
          pay_vld_nxt  = 1'b1;
          pay_sop_nxt  = (cur_idx == 12'd4);
          if (cur_idx == pkt_len - 12'd3) begin
            pay_eop_nxt = 1'b1;
            state_nxt   = CHK;
          end
        end
        CHK: begin
          if (cur_idx == pkt_len - 12'd2) begin
            chk_hi_nxt = rx_data;
          end else begin
            state_nxt = IDLE;
            if ({chk_hi, rx_data} == sum) begin
              pkt_ok_nxt = 1'b1;
            end else begin
              pkt_err_nxt     = 1'b1;
              err_code_nxt[0] = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and registered outputs; reset drops any packet without status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 12'd0;
      sum      <= 16'd0;
      chk_hi   <= 8'd0;
      num_hi   <= 3'd0;
      pkt_len  <= 12'd0;
      pay_data <= 8'd0;
      pay_vld  <= 1'b0;
      pay_sop  <= 1'b0;
      pay_eop  <= 1'b0;
      pkt_num  <= 11'd0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 3'b000;
      err_cnt  <= 16'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      sum      <= sum_nxt;
      chk_hi   <= chk_hi_nxt;
      num_hi   <= num_hi_nxt;
      pkt_len  <= pkt_len_nxt;
      pay_data <= pay_data_nxt;
      pay_vld  <= pay_vld_nxt;
      pay_sop  <= pay_sop_nxt;
      pay_eop  <= pay_eop_nxt;
      pkt_num  <= pkt_num_nxt;
      pkt_ok   <= pkt_ok_nxt;
      pkt_err  <= pkt_err_nxt;
      err_code <= err_code_nxt;
      err_cnt  <= pkt_err_nxt ? sat_inc(err_cnt) : err_cnt;
    end
  end

endmodule

// File: tb/tb_pac_rx_deframer.sv
// Directed bench for pac_rx_deframer: builds packets byte by byte, drives
// them on the falling edge and inspects the registered outputs 1 ns after
// each rising edge, so the outputs seen belong to the byte just driven.
module tb_pac_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pac_stp = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [7:0]  pay_data;
  logic        pay_vld, pay_sop, pay_eop;
  logic [10:0] pkt_num;
  logic        pkt_ok, pkt_err;
  logic [2:0]  err_code;
  logic [15:0] err_cnt;

  pac_rx_deframer dut (
    .clk(clk), .rst_n(rst_n), .pac_stp(pac_stp), .rx_data(rx_data),
    .pay_data(pay_data), .pay_vld(pay_vld), .pay_sop(pay_sop), .pay_eop(pay_eop),
    .pkt_num(pkt_num), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .err_cnt(err_cnt)
  );

  always #4 clk = ~clk;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  logic [7:0] pkt [0:2070];
  int plen;

  // observation counters, cleared at the start of each sent sequence
  int n_vld, n_sop, n_eop, n_ok, n_err, n_both, data_bad;
  int sop_at, eop_first, eop_last, ok_at, err_at, ok_cyc;
  logic [2:0] last_code;
  int ok_t1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input int num);
    return (num >= 16) ? 1943 : 2071;
  endfunction

  task automatic clear_mon();
    n_vld = 0; n_sop = 0; n_eop = 0; n_ok = 0; n_err = 0; n_both = 0; data_bad = 0;
    sop_at = -1; eop_first = -1; eop_last = -1; ok_at = -1; err_at = -1;
    last_code = 3'b000;
  endtask

  task automatic monitor(input int i);
    if (pay_vld) begin
      n_vld++;
      if (i < 0 || pay_data !== pkt[i]) data_bad++;
    end
    if (pay_sop) begin n_sop++; sop_at = i; end
    if (pay_eop) begin
      n_eop++;
      if (n_eop == 1) eop_first = i;
      eop_last = i;
    end
    if (pkt_ok) begin n_ok++; ok_at = i; ok_cyc = cyc; end
    if (pkt_err) begin n_err++; err_at = i; last_code = err_code; end
    if (pkt_ok && pkt_err) n_both++;
  endtask

  task automatic drive(input logic stp, input logic [7:0] b, input int i);
    @(negedge clk);
    pac_stp = stp;
    rx_data = b;
    @(posedge clk);
    #1;
    cyc++;
    monitor(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'(k * 13 + 1), -1);
  endtask

  task automatic build(input int num, input bit bad);
    logic [10:0] n11;
    logic [15:0] s;
    n11 = 11'(num);
    plen = len_of(num);
    s = 16'd0;
    pkt[0] = 8'hA5;
    pkt[1] = 8'h5A;
    pkt[2] = {5'b0, n11[10:8]};
    pkt[3] = n11[7:0];
    for (int i = 4; i <= plen - 3; i++) pkt[i] = 8'(i * 7 + num);
    for (int i = 0; i <= plen - 3; i++) s = s + {8'd0, pkt[i]};
    pkt[plen-2] = s[15:8];
    pkt[plen-1] = s[7:0] ^ (bad ? 8'h01 : 8'h00);
  endtask

  task automatic send_raw(input int n);
    clear_mon();
    for (int i = 0; i < n; i++) drive(i == 0, pkt[i], i);
  endtask

  initial begin
    // reset state
    #10;
    chk("rst_outputs_zero", 32'(|{pay_data, pay_vld, pay_sop, pay_eop, pkt_num, pkt_ok, pkt_err, err_code}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // video packet num=16
    build(16, 1'b0);
    send_raw(plen);
    chk("vid_vld_count", n_vld, 1937);
    chk("vid_data_bad", data_bad, 0);
    chk("vid_sop", {n_sop, sop_at}, {32'd1, 32'd4});
    chk("vid_eop", {n_eop, eop_last}, {32'd1, 32'd1940});
    chk("vid_ok_at", ok_at, 1942);
    chk("vid_ok_cnt", n_ok, 1);
    chk("vid_no_err", n_err, 0);
    chk("vid_pkt_num", 32'(pkt_num), 16);
    idle(4);

    // non-video num=3 then num=4 back to back
    build(3, 1'b0);
    send_raw(plen);
    chk("nv3_vld_count", n_vld, 2065);
    chk("nv3_ok", {n_ok, ok_at}, {32'd1, 32'd2070});
    ok_t1 = ok_cyc;
    build(4, 1'b0);
    send_raw(plen);
    chk("nv4_vld_count", n_vld, 2065);
    chk("nv4_data_bad", data_bad, 0);
    chk("nv4_ok_cnt", n_ok, 1);
    chk("b2b_no_err", n_err, 0);
    chk("b2b_ok_spacing", ok_cyc - ok_t1, 2071);
    chk("b2b_err_cnt", 32'(err_cnt), 0);
    chk("nv4_pkt_num", 32'(pkt_num), 4);
    idle(4);

    // corrupted checksum on num=5
    build(5, 1'b1);
    send_raw(plen);
    chk("sum_vld_count", n_vld, 2065);
    chk("sum_no_ok", n_ok, 0);
    chk("sum_err", {n_err, err_at}, {32'd1, 32'd2070});
    chk("sum_code", 32'(last_code), 32'b001);
    chk("sum_err_cnt", 32'(err_cnt), 1);
    idle(4);

    // header error: i1 = 00
    pkt[0] = 8'hA5; pkt[1] = 8'h00; pkt[2] = 8'h00; pkt[3] = 8'h07;
    pkt[4] = 8'h11; pkt[5] = 8'h22;
    send_raw(6);
    chk("hdr_err", {n_err, err_at}, {32'd1, 32'd1});
    chk("hdr_code", 32'(last_code), 32'b010);
    chk("hdr_no_vld", n_vld, 0);
    chk("hdr_pkt_num", 32'(pkt_num), 5);
    chk("hdr_err_cnt", 32'(err_cnt), 2);
    idle(4);

    // abort at i=1000 of a video packet, then packet num=20
    build(16, 1'b0);
    send_raw(1000);
    chk("abort_pre_vld", n_vld, 996);
    build(20, 1'b0);
    send_raw(plen);
    chk("abort_err", {n_err, err_at}, {32'd1, 32'd0});
    chk("abort_code", 32'(last_code), 32'b100);
    chk("abort_eop", {n_eop, eop_first, eop_last}, {32'd2, 32'd0, 32'd1940});
    chk("abort_new_ok", {n_ok, ok_at}, {32'd1, 32'd1942});
    chk("abort_new_vld", n_vld, 1937);
    chk("abort_new_data", data_bad, 0);
    chk("abort_pkt_num", 32'(pkt_num), 20);
    chk("abort_err_cnt", 32'(err_cnt), 3);
    chk("never_ok_and_err", n_both, 0);
    idle(4);

    // asynchronous reset at i=500
    build(16, 1'b0);
    send_raw(501);
    chk("pre_rst_vld", 32'(pay_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_zero", 32'(|{pay_data, pay_vld, pay_sop, pay_eop, pkt_num, pkt_ok, pkt_err, err_code}), 0);
    chk("async_rst_err_cnt", 32'(err_cnt), 0);
    clear_mon();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("post_rst_no_status", n_ok + n_err, 0);
    build(17, 1'b0);
    send_raw(plen);
    chk("post_rst_ok", {n_ok, ok_at}, {32'd1, 32'd1942});
    chk("post_rst_pkt_num", 32'(pkt_num), 17);
    idle(4);

    // err_cnt saturation
    @(negedge clk);
    force dut.err_cnt = 16'hFFFE;
    #1 release dut.err_cnt;
    pkt[0] = 8'hA5; pkt[1] = 8'h00;
    send_raw(2);
    idle(2);
    chk("sat_first", 32'(err_cnt), 32'hFFFF);
    send_raw(2);
    idle(2);
    chk("sat_hold", 32'(err_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
